// File: rtl/car_spawn_ctrl.sv
// Lane car spawner: paces shift strobes to the car shifter and decides per slot
// whether a car is inserted, enforcing a minimum empty-slot gap between cars.
//
// state | meaning
// IDLE  | game stopped, timing cleared, gap primed so the first slot may load
// RUN   | tick counter advancing, strobe issued at terminal count
// HOLD  | paused, tick counter frozen
module car_spawn_ctrl #(
  parameter int unsigned TICK_MAX = 50,
  parameter int unsigned MIN_GAP  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       pause,
  input  logic [8:0] sw,
  input  logic [9:0] random,
  output logic       press,
  output logic       load,
  output logic [7:0] car_count,
  output logic       busy
);

  localparam logic [15:0] TICK_LAST = 16'(TICK_MAX - 1);
  localparam logic [3:0]  GAP_MIN   = 4'(MIN_GAP);

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t      state;
  logic [15:0] tick_cnt;
  logic [3:0]  gap_cnt;
  logic        slot_ok;

  assign slot_ok = ({1'b0, sw} > random) && (gap_cnt >= GAP_MIN);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      gap_cnt   <= GAP_MIN;
      press     <= 1'b0;
      load      <= 1'b0;
      car_count <= '0;
      busy      <= 1'b0;
    end else begin
      press <= 1'b0;
      load  <= 1'b0;
      if (!enable) begin
        state    <= IDLE;
        tick_cnt <= '0;
        gap_cnt  <= GAP_MIN;
        busy     <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state    <= RUN;
            tick_cnt <= '0;
            busy     <= 1'b1;
          end
          RUN: begin
            busy <= 1'b1;
            if (pause) begin
              // a pause on the terminal-count edge swallows that strobe
              state <= HOLD;
            end else if (tick_cnt == TICK_LAST) begin
              tick_cnt <= '0;
              press    <= 1'b1;
              load     <= slot_ok;
              if (slot_ok) begin
                gap_cnt <= '0;
                if (car_count != 8'hFF) car_count <= car_count + 8'd1;
              end else if (gap_cnt < GAP_MIN) begin
                gap_cnt <= gap_cnt + 4'd1;
              end
            end else begin
              tick_cnt <= tick_cnt + 16'd1;
            end
          end
          HOLD: begin
            busy <= 1'b1;
            if (!pause) state <= RUN;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_car_spawn_ctrl.sv
// Bench for car_spawn_ctrl: vector table, hand-written corner sequences and
// randomized traffic against a slot-level reference model.
module tb_car_spawn_ctrl;
  localparam int TM = 4;
  localparam int MG = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       pause = 1'b0;
  logic [8:0] sw = '0;
  logic [9:0] random = '0;
  logic       press, load, busy;
  logic [7:0] car_count;
  logic       press0, load0, busy0;
  logic [7:0] car_count0;

  car_spawn_ctrl #(.TICK_MAX(TM), .MIN_GAP(MG)) dut (
    .clk(clk), .reset(reset), .enable(enable), .pause(pause), .sw(sw),
    .random(random), .press(press), .load(load), .car_count(car_count), .busy(busy)
  );

  car_spawn_ctrl #(.TICK_MAX(TM), .MIN_GAP(0)) dut0 (
    .clk(clk), .reset(reset), .enable(enable), .pause(pause), .sw(sw),
    .random(random), .press(press0), .load(load0), .car_count(car_count0), .busy(busy0)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: mode 0=stopped 1=running 2=frozen
  int m_mode, m_phase, m_slots, m_cars;
  bit m_press, m_load;

  function automatic void model_reset();
    m_mode = 0; m_phase = 0; m_slots = MG; m_cars = 0;
    m_press = 0; m_load = 0;
  endfunction

  function automatic void model_step();
    m_press = 0;
    m_load  = 0;
    if (!enable) begin
      m_mode = 0; m_phase = 0; m_slots = MG;
    end else if (m_mode == 0) begin
      m_mode = 1; m_phase = 0;
    end else if (pause) begin
      m_mode = 2;
    end else if (m_mode == 2) begin
      m_mode = 1;
    end else begin
      if (m_phase == TM - 1) begin
        m_press = 1;
        m_load  = (int'(sw) > int'(random)) && (m_slots >= MG);
        if (m_load) begin
          m_slots = 0;
          if (m_cars < 255) m_cars++;
        end else begin
          m_slots++;
        end
      end
      m_phase = (m_phase + 1) % TM;
    end
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // called at a falling edge: drive inputs, advance model, check after next rising edge
  task automatic cyc(input logic en, input logic p, input logic [8:0] s, input logic [9:0] r);
    logic [10:0] exp_v;
    enable = en; pause = p; sw = s; random = r;
    model_step();
    @(negedge clk);
    exp_v = {m_press, m_load, (m_mode != 0), 8'(m_cars)};
    check("model", {21'd0, press, load, busy, car_count}, {21'd0, exp_v});
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    check("reset_async", {28'd0, press, load, busy, |car_count}, 32'd0);
    model_reset();
    enable = 1'b0; pause = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  typedef struct {
    logic       en;
    logic       p;
    logic [8:0] s;
    logic [9:0] r;
    logic       ep;
    logic       el;
    logic       eb;
  } vec_t;

  vec_t vecs[23];

  initial begin
    int presses, loads, found;
    bit mono;
    logic [7:0] prev;

    // enable at 0, strobes at 4,8,12,16 loading 1,0,0,1; disable at 17, re-enter at 18, strobe at 22 loads
    for (int i = 0; i < 23; i++) begin
      vecs[i].en = (i != 17);
      vecs[i].p  = 1'b0;
      vecs[i].s  = 9'd511;
      vecs[i].r  = 10'd0;
      vecs[i].ep = (i == 4) || (i == 8) || (i == 12) || (i == 16) || (i == 22);
      vecs[i].el = (i == 4) || (i == 16) || (i == 22);
      vecs[i].eb = (i != 17);
    end

    @(negedge clk);
    do_reset();
    cyc(1'b0, 1'b0, 9'd511, 10'd0);
    check("idle_hold", {31'd0, busy}, 32'd0);

    for (int i = 0; i < 23; i++) begin
      cyc(vecs[i].en, vecs[i].p, vecs[i].s, vecs[i].r);
      check($sformatf("vec%0d", i), {29'd0, press, load, busy},
            {29'd0, vecs[i].ep, vecs[i].el, vecs[i].eb});
    end

    // pause on the terminal-count edge
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 9'd511, 10'd0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 1'b1, 9'd511, 10'd0);
      check("pause_press", {31'd0, press}, 32'd0);
      check("pause_tick", {16'd0, dut.tick_cnt}, 32'd3);
    end
    cyc(1'b1, 1'b0, 9'd511, 10'd0);
    check("resume_edge", {31'd0, press}, 32'd0);
    cyc(1'b1, 1'b0, 9'd511, 10'd0);
    check("resume_press", {30'd0, press, load}, 32'd3);

    // threshold: equal values never load, one below does
    do_reset();
    cyc(1'b1, 1'b0, 9'd100, 10'd100);
    presses = 0; loads = 0;
    for (int i = 0; i < 12; i++) begin
      cyc(1'b1, 1'b0, 9'd100, 10'd100);
      presses += press; loads += load;
    end
    check("thr_eq_press", presses, 3);
    check("thr_eq_load", loads, 0);
    loads = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b0, 9'd100, 10'd99);
      loads += load;
    end
    check("thr_lt_load", loads, 1);

    // disable mid-count right after a loaded slot; re-entry must allow a car at once
    cyc(1'b1, 1'b0, 9'd511, 10'd0);
    cyc(1'b1, 1'b0, 9'd511, 10'd0);
    cyc(1'b0, 1'b0, 9'd511, 10'd0);
    check("dis_busy", {31'd0, busy}, 32'd0);
    check("dis_tick", {16'd0, dut.tick_cnt}, 32'd0);
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 9'd511, 10'd0);
    check("reen_load", {30'd0, press, load}, 32'd3);

    // reset during a strobe cycle
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      cyc(1'b1, 1'b0, 9'd511, 10'd0);
      if (press) found = 1;
    end
    check("strobe_seen", found, 1);
    reset = 1'b0;
    #1;
    check("rst_mid_strobe", {22'd0, press, load, car_count}, 32'd0);
    model_reset();
    enable = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    // saturation with zero gap on the second instance
    do_reset();
    mono = 1; prev = 8'd0;
    for (int i = 0; i < 1220; i++) begin
      cyc(1'b1, 1'b0, 9'd511, 10'd0);
      if (car_count0 < prev) mono = 0;
      prev = car_count0;
    end
    check("sat_value", {24'd0, car_count0}, 32'd255);
    check("sat_nowrap", {31'd0, mono}, 32'd1);

    // randomized traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      cyc(logic'($urandom_range(0, 19) != 0), logic'($urandom_range(0, 5) == 0),
          9'($urandom), 10'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/car_spawn_ctrl.md
CAR_SPAWN_CTRL -- requirements
Module: car_spawn_ctrl

Interface
REQ-001 Parameter TICK_MAX, default 50: clock cycles between successive lane shift strobes; legal range 2..2^16-1.
REQ-002 Parameter MIN_GAP, default 2: minimum number of empty shift slots between loaded cars; legal range 0..15.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 enable  input  1  game running; 0 forces IDLE.
REQ-006 pause  input  1  freeze lane timing while high.
REQ-007 sw  input  9  difficulty threshold, unsigned.
REQ-008 random  input  10  pseudo-random value from the lane LFSR, unsigned.
REQ-009 press  output  1  one-cycle shift strobe to the downstream car shifter.
REQ-010 load  output  1  insert-car bit, meaningful only while press=1.
REQ-011 car_count  output  8  number of cars inserted since reset, saturating.
REQ-012 busy  output  1  high while in RUN or HOLD.

Function
REQ-013 FSM states SHALL be IDLE, RUN and HOLD, encoded internally.
REQ-014 IDLE->RUN SHALL occur on the rising edge where enable=1; in that transition the tick counter is cleared to 0.
REQ-015 RUN->HOLD SHALL occur on the rising edge where pause=1 and enable=1.
REQ-016 HOLD->RUN SHALL occur on the rising edge where pause=0 and enable=1.
REQ-017 Any state->IDLE SHALL occur on the rising edge where enable=0; enable=0 dominates pause.
REQ-018 Tick counter (16 bit) SHALL increment each cycle in RUN with pause=0 and wrap from TICK_MAX-1 to 0.
REQ-019 In HOLD the tick counter SHALL hold its value; in IDLE it SHALL be 0.
REQ-020 press SHALL be registered: it is 1 for exactly the one cycle following an edge at which the state is RUN, enable=1, pause=0 and the counter is TICK_MAX-1; otherwise it is 0.
REQ-021 First press after entering RUN SHALL appear TICK_MAX cycles after the entering edge; subsequent presses occur every TICK_MAX cycles while unpaused.
REQ-022 load SHALL be registered on the same edge as press and equals (sw > random, zero-extended 10-bit unsigned compare) AND (gap_cnt >= MIN_GAP).
REQ-023 load SHALL be 0 in every cycle where press is 0.
REQ-024 gap_cnt (4 bit) SHALL be cleared to 0 on the edge producing press=1 with load=1. On the edge producing press=1 with load=0 it SHALL increment, saturating at MIN_GAP.
REQ-025 gap_cnt SHALL be set to MIN_GAP on entry to IDLE, so that the first slot after enable may carry a car.
REQ-026 car_count SHALL increment by 1 on each edge that produces press=1 with load=1, and SHALL saturate at 255.
REQ-027 car_count SHALL be cleared only by reset, not by IDLE.
REQ-028 A pause raised on the terminal-count edge SHALL suppress that press; the press then appears one cycle after the HOLD->RUN edge.
REQ-029 busy SHALL be a registered decode of state; it is 1 in RUN and HOLD.

Reset
REQ-030 reset=0 SHALL immediately, without a clock, force state=IDLE, counter=0, gap_cnt=MIN_GAP, press=0, load=0, car_count=0 and busy=0.
REQ-031 Reset asserted mid-strobe SHALL drop press and load in the same cycle.
REQ-032 After release, the block SHALL remain in IDLE until the first edge with enable=1.

Verification (TICK_MAX=4, MIN_GAP=2)
REQ-033 Basic cadence. Stimulus: release reset, enable=1, pause=0, sw=9'd511, random=0. Response: press is high for 1 cycle every 4 cycles; the first press is 4 cycles after enable is sampled; the load pattern is 1,0,0,1,0,0,...
REQ-034 Threshold. Stimulus: sw=9'd100, random=10'd100, then random=10'd99. Response: load=0 on every press while random=100; load=1 on the first allowed slot after random becomes 99.
REQ-035 Pause. Stimulus: pause=1 on the terminal-count edge, held for 5 cycles. Response: no press during the pause, counter held at 3, and press appears 1 cycle after the edge where pause=0 is sampled.
REQ-036 Saturation. Stimulus: MIN_GAP=0, sw=511, random=0, run for 300 presses. Response: car_count stops at 8'd255 and does not wrap.
REQ-037 Disable and reset. Stimulus: enable=0 mid-count, then re-enable; separately, assert reset=0 during a press cycle. Response: on disable, busy=0, the counter restarts from 0 and the first slot can load. On reset, press=0, load=0 and car_count=0 immediately.
